ppm_data_encoder: RTL and testbench

Downstream companion of the SOF generator in the PPM transmitter. After the SOF pattern completes (`sof_done`), this block encodes a stream of payload bytes into 1-of-4 pulse-position symbols and appends an EOF pattern. Its output line idles high and is ANDed with the SOF output to form the transmitter line. Byte timing matches the SOF block: a 16-clock pulse slot at the 0.59 µs clock, which is 9.44 µs.

---
 rtl/ppm_data_encoder.sv | 207 ++++++++++++++++++++
 tb/tb_ppm_data_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_data_encoder.sv
// ppm_data_encoder
// Encodes payload bytes into 1-of-4 pulse-position symbols after the SOF
// pattern, then appends an EOF pattern (one slot low, one slot high).
// The line idles high; a pulse is a low slot. All outputs are registered,
// so the line shows a counter position one clock after the counters reach it.
module ppm_data_encoder #(
  parameter int SLOT_CLKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_last,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       ppm_out,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int CW = $clog2(SLOT_CLKS);
  // Combined counter width: clk_cnt + 3-bit slot + 2-bit symbol.
  localparam int TW = CW + 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_EOF
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Position counters; concatenated they form one free-running byte counter.
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_slot_idx;
  logic [1:0]    r_sym_idx;
  logic [TW-1:0] w_cnt;
  logic [TW-1:0] w_cnt_inc;

  // Holding register (prefetch) and shift register (byte on the line).
  logic [7:0] r_hold_byte;
  logic       r_hold_last;
  logic       r_full;
  logic [7:0] r_shift_byte;
  logic       r_shift_last;

  // Registered outputs.
  logic r_ppm_out;
  logic r_busy;
  logic r_frame_done;
  logic r_underrun;
  logic r_data_ready;
  // Underrun raised by a start with nothing to send is shown one clock
  // later, aligned with the first EOF clock on the line.
  logic r_underrun_pend;

  logic       w_boundary;
  logic       w_eof_end;
  logic       w_load;
  logic       w_clr_cnt;
  logic       w_underrun_now;
  logic       w_underrun_late;
  logic       w_accept;
  logic       w_full_next;
  logic [1:0] w_sym [4];
  logic [1:0] w_sym_val;
  logic       w_ppm_next;

  // Symbol k of the byte being encoded is bit pair [2k+1:2k].
  for (genvar gi = 0; gi < 4; gi++) begin : g_sym
    assign w_sym[gi] = r_shift_byte[2*gi+1 -: 2];
  end

  assign w_sym_val  = w_sym[r_sym_idx];
  assign w_cnt      = {r_sym_idx, r_slot_idx, r_clk_cnt};
  assign w_cnt_inc  = w_cnt + TW'(1);
  assign w_boundary = (&r_clk_cnt) & (&r_slot_idx) & (&r_sym_idx);
  assign w_eof_end  = (r_slot_idx == 3'd1) & (&r_clk_cnt);

  assign w_accept    = data_valid & ~r_full;
  assign w_full_next = w_accept ? 1'b1 : (w_load ? 1'b0 : r_full);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    w_state_next    = r_state;
    w_load          = 1'b0;
    w_clr_cnt       = 1'b0;
    w_underrun_now  = 1'b0;
    w_underrun_late = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clr_cnt = 1'b1;
          if (r_full) begin
            w_state_next = S_DATA;
            w_load       = 1'b1;
          end else begin
            w_state_next    = S_EOF;
            w_underrun_late = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_boundary) begin
          if (r_shift_last) begin
            w_state_next = S_EOF;
          end else if (r_full) begin
            w_load = 1'b1;
          end else begin
            w_underrun_now = 1'b1;
            w_state_next   = S_EOF;
          end
        end
      end
      S_EOF: begin
        if (w_eof_end) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Position counters: cleared on start, free-running (with wrap) while active.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt  <= '0;
      r_slot_idx <= '0;
      r_sym_idx  <= '0;
    end else if (w_clr_cnt) begin
      r_clk_cnt  <= '0;
      r_slot_idx <= '0;
      r_sym_idx  <= '0;
    end else if (r_state != S_IDLE) begin
      {r_sym_idx, r_slot_idx, r_clk_cnt} <= w_cnt_inc;
    end
  end

  // Holding register accepts in any state; shift register loads on unload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_byte  <= '0;
      r_hold_last  <= 1'b0;
      r_full       <= 1'b0;
      r_shift_byte <= '0;
      r_shift_last <= 1'b0;
    end else begin
      r_full <= w_full_next;
      if (w_accept) begin
        r_hold_byte <= data_in;
        r_hold_last <= data_last;
      end
      if (w_load) begin
        r_shift_byte <= r_hold_byte;
        r_shift_last <= r_hold_last;
      end
    end
  end

  // Line level for the current counter position: symbol v pulls slot 2v+1
  // low; EOF is low for slot 0 and high for slot 1.
  always_comb begin
    w_ppm_next = 1'b1;
    case (r_state)
      S_DATA:  w_ppm_next = (r_slot_idx != {w_sym_val, 1'b1});
      S_EOF:   w_ppm_next = (r_slot_idx != 3'd0);
      default: w_ppm_next = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ppm_out       <= 1'b1;
      r_busy          <= 1'b0;
      r_frame_done    <= 1'b0;
      r_underrun      <= 1'b0;
      r_underrun_pend <= 1'b0;
      r_data_ready    <= 1'b1;
    end else begin
      r_ppm_out       <= w_ppm_next;
      r_busy          <= (r_state != S_IDLE);
      r_frame_done    <= (r_state == S_EOF) & w_eof_end;
      r_underrun      <= w_underrun_now | r_underrun_pend;
      r_underrun_pend <= w_underrun_late;
      r_data_ready    <= ~w_full_next;
    end
  end

  assign ppm_out    = r_ppm_out;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;
  assign data_ready = r_data_ready;

endmodule

// File: tb/tb_ppm_data_encoder.sv
// Testbench for ppm_data_encoder: a reference model expands each frame into
// its expected per-clock line trace; a monitor pops one entry per busy clock.
module tb_ppm_data_encoder;

  localparam int SLOT = 16;
  localparam int BC   = 32 * SLOT;  // clocks per byte

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       data_last;
  logic       data_valid;
  logic       data_ready;
  logic       ppm_out;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  always #5 clk = ~clk;

  ppm_data_encoder #(.SLOT_CLKS(SLOT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .data_last  (data_last),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ppm_out    (ppm_out),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  typedef struct packed {
    logic ppm;
    logic busy;
    logic fd;
    logic ur;
    logic rdy;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] feed_q[$];   // {last, byte} waiting for the producer handshake
  logic [7:0] frame_q[$];  // bytes of the frame being set up

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: one expected entry per busy clock, idle line otherwise.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("busy_unexpected", 32'(busy), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("line{ppm,busy,done,underrun}",
                32'({ppm_out, busy, frame_done, underrun}),
                32'({e.ppm, e.busy, e.fd, e.ur}));
          check("data_ready", 32'(data_ready), 32'(e.rdy));
        end
      end else begin
        check("idle{ppm,done,underrun}", 32'({ppm_out, frame_done, underrun}), 32'b100);
      end
    end
  end

  task automatic drive_feed();
    if (feed_q.size() > 0) begin
      data_valid = 1'b1;
      {data_last, data_in} = feed_q[0];
    end else begin
      data_valid = 1'b0;
    end
  endtask

  // Advance one clock; retire a byte the DUT accepted on that edge.
  task automatic tick();
    bit acc;
    acc = data_valid && data_ready;
    @(posedge clk);
    #1;
    if (acc && feed_q.size() > 0) void'(feed_q.pop_front());
    drive_feed();
  endtask

  // Reference model: expected trace for offsets 1.. after the start edge.
  // n bytes from frame_q, then (optionally) underrun, then EOF.
  task automatic push_expected(input int n, input bit under);
    int   t;
    int   v;
    exp_t e;
    t = 0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        v = (int'(frame_q[i]) >> (2 * k)) & 3;
        for (int s = 0; s < 8; s++)
          for (int c = 0; c < SLOT; c++) begin
            t++;
            e.ppm  = (s != 2 * v + 1);
            e.busy = 1'b1;
            e.fd   = 1'b0;
            e.ur   = under && (i == n - 1) && (k == 3) && (s == 7) && (c == SLOT - 1);
            e.rdy  = (t > BC * (n - 1)) || (t % BC == 0);
            exp_q.push_back(e);
          end
      end
    for (int j = 0; j < 2 * SLOT; j++) begin
      t++;
      e.ppm  = (j >= SLOT);
      e.busy = 1'b1;
      e.fd   = (j == 2 * SLOT - 1);
      e.ur   = under && (n == 0) && (j == 0);
      e.rdy  = (t > BC * (n - 1)) || (t % BC == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic recover();
    exp_q.delete();
    feed_q.delete();
    drive_feed();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Run one frame from frame_q. under: no last flag, frame ends in underrun.
  // held: frame_q[0] already sits in the holding register.
  task automatic run_frame(input bit under, input bit held, input int mid_at, input int rst_at);
    int n;
    int t;
    n = frame_q.size();
    for (int i = (held ? 1 : 0); i < n; i++)
      feed_q.push_back({(!under && i == n - 1), frame_q[i]});
    drive_feed();
    if (!held && n > 0) begin
      for (int c = 0; c < 20 && feed_q.size() > n - 1; c++) tick();
      check("prefetch_accept", 32'(feed_q.size()), 32'(n - 1));
    end
    push_expected(n, under);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (exp_q.size() > 0 && t < BC * n + 2 * SLOT + 50) begin
      start = (mid_at > 0 && t + 1 == mid_at);
      if (rst_at > 0 && t + 1 == rst_at) rst = 1'b1;
      tick();
      t++;
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        exp_q.delete();
        check("rst_ppm_out", 32'(ppm_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
      end
    end
    check("frame_drained", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() > 0) recover();
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic feed_byte(input logic [7:0] b, input bit last);
    feed_q.push_back({last, b});
    drive_feed();
    for (int c = 0; c < 20 && feed_q.size() > 0; c++) tick();
    check("late_accept", 32'(feed_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    int mid;
    bit under;

    rst        = 1'b1;
    start      = 1'b0;
    data_in    = '0;
    data_last  = 1'b0;
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ppm_out", 32'(ppm_out), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    check("reset_data_ready", 32'(data_ready), 32'd1);
    mon_en = 1'b1;
    tick();

    // Single prefetched byte 0xE4 with last.
    frame_q = '{8'hE4};
    run_frame(1'b0, 1'b0, 0, 0);
    // Three seamless bytes.
    frame_q = '{8'h00, 8'hFF, 8'h1B};
    run_frame(1'b0, 1'b0, 0, 0);
    // Second byte withheld: underrun after one byte, late byte kept for next frame.
    frame_q = '{8'hA5};
    run_frame(1'b1, 1'b0, 0, 0);
    feed_byte(8'h3C, 1'b1);
    frame_q = '{8'h3C};
    run_frame(1'b0, 1'b1, 0, 0);
    // Start with empty holding register.
    frame_q.delete();
    run_frame(1'b1, 1'b0, 0, 0);
    // Reset during byte 0, then a clean frame.
    frame_q = '{8'h96};
    run_frame(1'b0, 1'b0, 0, 300);
    frame_q = '{8'h5A};
    run_frame(1'b0, 1'b0, 0, 0);
    // Extra start mid-frame is ignored.
    frame_q = '{8'hE4};
    run_frame(1'b0, 1'b0, 200, 0);

    // Randomized frames.
    for (int r = 0; r < 12; r++) begin
      n     = $urandom_range(0, 3);
      under = (n == 0) || ($urandom_range(0, 3) == 0);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
      mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, BC * n + 2 * SLOT)) : 0;
      run_frame(under, 1'b0, mid, 0);
      if (under && n > 0) begin
        n2 = $urandom_range(1, 2);
        frame_q.delete();
        for (int i = 0; i < n2; i++) frame_q.push_back(8'($urandom));
        feed_byte(frame_q[0], n2 == 1);
        run_frame(1'b0, 1'b1, 0, 0);
      end
    end

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
